// File: rtl/adc_axis_capture.sv
// adc_axis_capture: AXI4-Stream sink that arms, aligns to a frame boundary (tlast),
// captures exactly one frame into an internal RAM, checks length/tkeep and exposes the
// RAM through a registered read port.
// Optional feature macro: ADC_CAPTURE_PATTERN_CHECK_EN (adds PATTERN parameter and the
// err_count port with per-half-word pattern comparison of stored beats).
module adc_axis_capture #(
  parameter int unsigned ADDR_W  = 10
`ifdef ADC_CAPTURE_PATTERN_CHECK_EN
  ,
  parameter logic [15:0] PATTERN = 16'hAAAA
`endif
) (
  input  logic              s00_axis_aclk,
  input  logic              s00_axis_aresetn,
  input  logic              s00_axis_tvalid,
  input  logic [31:0]       s00_axis_tdata,
  input  logic [3:0]        s00_axis_tkeep,
  input  logic              s00_axis_tlast,
  output logic              s00_axis_tready,
  input  logic              arm,
  input  logic [ADDR_W:0]   expected_len,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic              keep_err,
  output logic [ADDR_W:0]   word_count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
`ifdef ADC_CAPTURE_PATTERN_CHECK_EN
  ,
  output logic [15:0]       err_count
`endif
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               tready_q;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               len_err_q, len_err_d;
  logic               keep_err_q, keep_err_d;
  logic [CNT_W-1:0]   wc_q, wc_d;
  logic [31:0]        rd_data_q;
  logic [31:0]        mem [DEPTH];

  logic               beat_c;
  logic               full_c;
  logic               store_c;

  assign beat_c  = s00_axis_tvalid & tready_q;
  assign full_c  = (wc_q == CNT_W'(DEPTH));
  assign store_c = (state_q == CAPTURE) & beat_c & ~arm & ~full_c;

  // State register
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) state_q <= IDLE;
    else                   state_q <= state_d;
  end

  // Next-state logic: arm restarts from any state
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = WAIT_SOF;
    end else begin
      case (state_q)
        WAIT_SOF: if (beat_c && s00_axis_tlast) state_d = CAPTURE;
        CAPTURE:  if (beat_c && s00_axis_tlast) state_d = DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  // Status outputs decoded from the next state so they line up with the state register
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      WAIT_SOF, CAPTURE: busy_d = 1'b1;
      DONE:              done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

`ifdef ADC_CAPTURE_PATTERN_CHECK_EN
  logic [15:0] err_q, err_d;
  logic [1:0]  mism_c;
  logic [16:0] err_sum_c;

  // Half-word mismatch count for the current beat and saturating accumulate
  always_comb begin
    mism_c    = 2'(s00_axis_tdata[15:0] != PATTERN) + 2'(s00_axis_tdata[31:16] != PATTERN);
    err_sum_c = {1'b0, err_q} + 17'(mism_c);
    err_d     = err_q;
    if (arm)          err_d = 16'h0000;
    else if (store_c) err_d = err_sum_c[16] ? 16'hFFFF : err_sum_c[15:0];
  end

  // Pattern error counter register
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) err_q <= 16'h0000;
    else                   err_q <= err_d;
  end

  assign err_count = err_q;
`endif

  // Capture datapath: word count and sticky per-capture error flags
  always_comb begin
    wc_d       = wc_q;
    len_err_d  = len_err_q;
    keep_err_d = keep_err_q;
    if (arm) begin
      wc_d       = '0;
      len_err_d  = 1'b0;
      keep_err_d = 1'b0;
    end else if (state_q == CAPTURE && beat_c) begin
      if (full_c) begin
        len_err_d = 1'b1;
      end else begin
        wc_d = wc_q + CNT_W'(1);
        if (s00_axis_tkeep != 4'hF) keep_err_d = 1'b1;
        if (s00_axis_tlast && (wc_q + CNT_W'(1) != expected_len)) len_err_d = 1'b1;
      end
    end
  end

  // Control and status registers
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      tready_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
      keep_err_q <= 1'b0;
      wc_q       <= '0;
    end else begin
      tready_q   <= 1'b1;
      busy_q     <= busy_d;
      done_q     <= done_d;
      len_err_q  <= len_err_d;
      keep_err_q <= keep_err_d;
      wc_q       <= wc_d;
    end
  end

  // Capture RAM write port
  always_ff @(posedge s00_axis_aclk) begin
    if (store_c) mem[wc_q[ADDR_W-1:0]] <= s00_axis_tdata;
  end

  // Registered readback; same-cycle write returns the old word
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) rd_data_q <= 32'h0;
    else                   rd_data_q <= mem[rd_addr];
  end

  assign s00_axis_tready = tready_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign len_err         = len_err_q;
  assign keep_err        = keep_err_q;
  assign word_count      = wc_q;
  assign rd_data         = rd_data_q;

endmodule

// File: tb/tb_adc_axis_capture.sv
// Directed bench for adc_axis_capture: a default-depth instance (ADDR_W=10) and a
// 16-word instance (ADDR_W=4) share the stream inputs; each has its own arm/readback.
module tb_adc_axis_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;

  logic        tready, busy, done, len_err, keep_err, arm;
  logic [10:0] exp_len, wc;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;

  logic        tready4, busy4, done4, len_err4, keep_err4, arm4;
  logic [4:0]  exp_len4, wc4;
  logic [3:0]  rd_addr4;
  logic [31:0] rd_data4;

`ifdef ADC_CAPTURE_PATTERN_CHECK_EN
  logic [15:0] err_count, err_count4;
`endif

  int n_cmp = 0;
  int n_err = 0;

  adc_axis_capture #(.ADDR_W(10)) dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s00_axis_tvalid(tvalid),
    .s00_axis_tdata(tdata), .s00_axis_tkeep(tkeep), .s00_axis_tlast(tlast),
    .s00_axis_tready(tready), .arm(arm), .expected_len(exp_len), .busy(busy),
    .done(done), .len_err(len_err), .keep_err(keep_err), .word_count(wc),
    .rd_addr(rd_addr), .rd_data(rd_data)
`ifdef ADC_CAPTURE_PATTERN_CHECK_EN
    , .err_count(err_count)
`endif
  );

  adc_axis_capture #(.ADDR_W(4)) dut4 (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s00_axis_tvalid(tvalid),
    .s00_axis_tdata(tdata), .s00_axis_tkeep(tkeep), .s00_axis_tlast(tlast),
    .s00_axis_tready(tready4), .arm(arm4), .expected_len(exp_len4), .busy(busy4),
    .done(done4), .len_err(len_err4), .keep_err(keep_err4), .word_count(wc4),
    .rd_addr(rd_addr4), .rd_data(rd_data4)
`ifdef ADC_CAPTURE_PATTERN_CHECK_EN
    , .err_count(err_count4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One beat presented for one clock; returns on the following falling edge
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    tvalid = 1'b1;
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    tkeep  = 4'hF;
  endtask

  task automatic frame(input int n, input logic [31:0] d0, input bit incr);
    for (int i = 0; i < n; i++) send(incr ? d0 + 32'(i) : d0, 4'hF, i == n - 1);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic pulse_arm4();
    arm4 = 1'b1;
    @(negedge clk);
    arm4 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tvalid = 1'b0; tdata = '0; tkeep = 4'hF; tlast = 1'b0;
    arm = 1'b0; arm4 = 1'b0; exp_len = 11'd1024; exp_len4 = 5'd16;
    rd_addr = '0; rd_addr4 = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_tready", 32'(tready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    chk("rst_keep_err", 32'(keep_err), 32'd0);
    chk("rst_wc", 32'(wc), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_tready", 32'(tready), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);

    // full 1024-beat frames: first aligns, second is captured
    pulse_arm();
    chk("t1_busy_arm", 32'(busy), 32'd1);
    frame(1024, 32'hAAAAAAAA, 1'b0);
    chk("t1_first_discard_wc", 32'(wc), 32'd0);
    chk("t1_first_done", 32'(done), 32'd0);
    for (int i = 0; i < 1023; i++) send(32'hAAAAAAAA, 4'hF, 1'b0);
    chk("t1_wc_1023", 32'(wc), 32'd1023);
    chk("t1_done_before_last", 32'(done), 32'd0);
    send(32'hAAAAAAAA, 4'hF, 1'b1);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_wc", 32'(wc), 32'd1024);
    chk("t1_len_err", 32'(len_err), 32'd0);
    chk("t1_keep_err", 32'(keep_err), 32'd0);
`ifdef ADC_CAPTURE_PATTERN_CHECK_EN
    chk("t1_err_count", 32'(err_count), 32'd0);
`endif
    frame(3, 32'h12345678, 1'b0);
    chk("done_discard_wc", 32'(wc), 32'd1024);
    chk("done_hold", 32'(done), 32'd1);

    // short frame (1000 of 1024) with counting data, then readback
    pulse_arm();
    send(32'h0, 4'hF, 1'b1);
    chk("t2_wc_after_sof", 32'(wc), 32'd0);
    frame(1000, 32'h10000000, 1'b1);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_wc", 32'(wc), 32'd1000);
    chk("t2_len_err", 32'(len_err), 32'd1);
    chk("t2_keep_err", 32'(keep_err), 32'd0);
    rd_addr = 10'd5;
    @(negedge clk);
    chk("rd_addr5", rd_data, 32'h10000005);
    rd_addr = 10'd999;
    @(negedge clk);
    chk("rd_addr999", rd_data, 32'h100003E7);

    // expected_len=1 boundary; SOF beat with bad tkeep is not checked; read-during-write
    exp_len = 11'd1;
    pulse_arm();
    send(32'h0, 4'h0, 1'b1);
    chk("len1_keep_sof", 32'(keep_err), 32'd0);
    rd_addr = 10'd0;
    send(32'hCAFEF00D, 4'hF, 1'b1);
    chk("rd_old_on_write", rd_data, 32'h10000000);
    chk("len1_done", 32'(done), 32'd1);
    chk("len1_wc", 32'(wc), 32'd1);
    chk("len1_len_err", 32'(len_err), 32'd0);
    @(negedge clk);
    chk("rd_new_after_write", rd_data, 32'hCAFEF00D);

    // abort mid-capture with arm coinciding with a beat
    exp_len = 11'd1024;
    pulse_arm();
    send(32'h0, 4'hF, 1'b1);
    for (int i = 0; i < 300; i++) send(32'hAAAAAAAA, (i == 7) ? 4'h3 : 4'hF, 1'b0);
    chk("t4_wc_300", 32'(wc), 32'd300);
    chk("t4_keep_pre", 32'(keep_err), 32'd1);
    arm = 1'b1;
    send(32'hAAAAAAAA, 4'hF, 1'b0);
    arm = 1'b0;
    chk("t4_wc_cleared", 32'(wc), 32'd0);
    chk("t4_keep_cleared", 32'(keep_err), 32'd0);
    chk("t4_len_cleared", 32'(len_err), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_done", 32'(done), 32'd0);
    for (int i = 0; i < 10; i++) send(32'hAAAAAAAA, 4'hF, 1'b0);
    send(32'hAAAAAAAA, 4'hF, 1'b1);
    chk("t4_tail_discard", 32'(wc), 32'd0);
    frame(1024, 32'hAAAAAAAA, 1'b0);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_wc", 32'(wc), 32'd1024);
    chk("t4_len_err", 32'(len_err), 32'd0);
    chk("t4_keep_err", 32'(keep_err), 32'd0);

    // tkeep and pattern errors on stored beats
    exp_len = 11'd4;
    pulse_arm();
    send(32'h0, 4'h0, 1'b1);
    chk("t5_keep_sof", 32'(keep_err), 32'd0);
    send(32'hAAAAAAAA, 4'h3, 1'b0);
    send(32'hAAAA5555, 4'hF, 1'b0);
    send(32'hAAAAAAAA, 4'hF, 1'b0);
    send(32'hAAAAAAAA, 4'hF, 1'b1);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_wc", 32'(wc), 32'd4);
    chk("t5_keep_err", 32'(keep_err), 32'd1);
    chk("t5_len_err", 32'(len_err), 32'd0);
`ifdef ADC_CAPTURE_PATTERN_CHECK_EN
    chk("t5_err_count", 32'(err_count), 32'd1);
`endif

    // 16-word instance: 20-beat frame overflows
    pulse_arm4();
    send(32'h0, 4'hF, 1'b1);
    for (int i = 0; i < 20; i++) begin
      send(32'h20000000 + 32'(i), 4'hF, i == 19);
      if (i == 15) begin
        chk("t3_wc_full", 32'(wc4), 32'd16);
        chk("t3_len_at_full", 32'(len_err4), 32'd0);
      end
      if (i == 16) begin
        chk("t3_len_overflow", 32'(len_err4), 32'd1);
        chk("t3_wc_held", 32'(wc4), 32'd16);
        chk("t3_not_done", 32'(done4), 32'd0);
      end
    end
    chk("t3_done", 32'(done4), 32'd1);
    chk("t3_wc", 32'(wc4), 32'd16);
    chk("t3_len_err", 32'(len_err4), 32'd1);
    rd_addr4 = 4'd15;
    @(negedge clk);
    chk("t3_rd15", rd_data4, 32'h2000000F);
    rd_addr4 = 4'd0;
    @(negedge clk);
    chk("t3_rd0", rd_data4, 32'h20000000);

    // exact-depth frame on the 16-word instance
    pulse_arm4();
    send(32'h0, 4'hF, 1'b1);
    frame(16, 32'h30000000, 1'b1);
    chk("exact_done", 32'(done4), 32'd1);
    chk("exact_wc", 32'(wc4), 32'd16);
    chk("exact_len_err", 32'(len_err4), 32'd0);

    // asynchronous reset mid-capture
    exp_len = 11'd1024;
    pulse_arm();
    send(32'h0, 4'hF, 1'b1);
    for (int i = 0; i < 10; i++) send(32'hAAAAAAAA, (i == 2) ? 4'h3 : 4'hF, 1'b0);
    chk("t6_wc_pre", 32'(wc), 32'd10);
    chk("t6_keep_pre", 32'(keep_err), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_tready", 32'(tready), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_keep", 32'(keep_err), 32'd0);
    chk("t6_len", 32'(len_err), 32'd0);
    chk("t6_wc", 32'(wc), 32'd0);
    chk("t6_rd_data", rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_tready_rel", 32'(tready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
